// File: rtl/osr_ctrl_pkg.sv
// Shared types and helpers for the OSR sequencer.
// Optional feature macro: OSR_CTRL_BG_REFILL_EN (background autopull refill while idle).
package osr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OUT_REFILL,
        OUT_WAIT,
        PULL_WAIT
    } osr_ctrl_state_t;

    typedef enum logic [1:0] {
        SRC_FIFO,
        SRC_X,
        SRC_MOV
    } osr_load_src_t;

    localparam logic [5:0] OSR_COUNT_EMPTY = 6'd32;

    // 5-bit bit-count fields use 0 to mean a full 32-bit word
    function automatic logic [5:0] decode_32(input logic [4:0] v);
        return (v == 5'd0) ? 6'd32 : {1'b0, v};
    endfunction

endpackage

// File: rtl/osr_shift_counter.sv
// Saturating 0..32 count of bits shifted out of the OSR since its last load.
// Resets to 32 so a freshly reset OSR reads as empty.
module osr_shift_counter
    import osr_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add_en,
    input  logic [5:0] add_val,
    output logic [5:0] count
);

    logic [6:0] sum;

    // widened sum so the saturation compare sees any carry
    always_comb begin
        sum = {1'b0, count} + {1'b0, add_val};
    end

    // clear wins over add; add saturates at a full word
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= OSR_COUNT_EMPTY;
        end else if (clear) begin
            count <= '0;
        end else if (add_en) begin
            count <= (sum > {1'b0, OSR_COUNT_EMPTY}) ? OSR_COUNT_EMPTY : sum[5:0];
        end
    end

endmodule

// File: rtl/osr_ctrl.sv
// OSR sequencer: turns OUT / PULL / MOV-to-OSR requests into OSR load/shift
// strobes, TX FIFO pops and a stall back to the core.
// Optional feature macro: OSR_CTRL_BG_REFILL_EN. When defined, an idle
// controller refills an exhausted OSR from the FIFO without waiting for an OUT.
//
// state      | meaning
// IDLE       | no request in flight; new requests decoded here
// OUT_REFILL | OSR reloaded for a pending OUT; shift happens this cycle
// OUT_WAIT   | OUT needs an autopull refill but the FIFO is empty
// PULL_WAIT  | blocking PULL waiting for the FIFO to become non-empty
module osr_ctrl
    import osr_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         out_req,
    input  logic [4:0]   out_bits,
    input  logic         pull_req,
    input  logic         pull_block,
    input  logic         pull_ifempty,
    input  logic         mov_req,
    input  logic [W-1:0] mov_data,
    input  logic [W-1:0] x_reg,
    input  logic         autopull_en,
    input  logic [4:0]   pull_thresh,
    input  logic [W-1:0] fifo_data,
    input  logic         fifo_empty,
    output logic         fifo_pop,
    output logic         osr_load,
    output logic [W-1:0] osr_data_in,
    output logic         osr_shift_en,
    output logic [5:0]   osr_shift_cnt,
    output logic         done,
    output logic         stall,
    output logic [5:0]   osr_count
);

    osr_ctrl_state_t state;
    osr_ctrl_state_t state_nx;
    osr_load_src_t   load_src;
    logic [5:0]      thresh_val;
    logic [5:0]      bits_val;
    logic            refill_due;
    logic            cnt_clear;
    logic            cnt_add;

    osr_shift_counter u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .add_en  (cnt_add),
        .add_val (bits_val),
        .count   (osr_count)
    );

    // decode requests against the live config and count; all strobes held low in reset
    always_comb begin
        thresh_val = decode_32(pull_thresh);
        bits_val   = decode_32(out_bits);
        refill_due = autopull_en && (osr_count >= thresh_val);
        state_nx   = state;
        load_src   = SRC_FIFO;
        fifo_pop   = 1'b0;
        osr_load   = 1'b0;
        osr_shift_en = 1'b0;
        done       = 1'b0;
        cnt_clear  = 1'b0;
        cnt_add    = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (mov_req) begin
                        load_src  = SRC_MOV;
                        osr_load  = 1'b1;
                        cnt_clear = 1'b1;
                        done      = 1'b1;
                    end else if (pull_req) begin
                        if (pull_ifempty && (osr_count < thresh_val)) begin
                            done = 1'b1;
                        end else if (!fifo_empty) begin
                            fifo_pop  = 1'b1;
                            osr_load  = 1'b1;
                            cnt_clear = 1'b1;
                            done      = 1'b1;
                        end else if (pull_block) begin
                            state_nx = PULL_WAIT;
                        end else begin
                            load_src  = SRC_X;
                            osr_load  = 1'b1;
                            cnt_clear = 1'b1;
                            done      = 1'b1;
                        end
                    end else if (out_req) begin
                        if (refill_due) begin
                            if (!fifo_empty) begin
                                fifo_pop  = 1'b1;
                                osr_load  = 1'b1;
                                cnt_clear = 1'b1;
                                state_nx  = OUT_REFILL;
                            end else begin
                                state_nx = OUT_WAIT;
                            end
                        end else begin
                            osr_shift_en = 1'b1;
                            cnt_add      = 1'b1;
                            done         = 1'b1;
                        end
                    end
`ifdef OSR_CTRL_BG_REFILL_EN
                    else if (refill_due && !fifo_empty) begin
                        fifo_pop  = 1'b1;
                        osr_load  = 1'b1;
                        cnt_clear = 1'b1;
                    end
`endif
                end
                OUT_REFILL: begin
                    // count was cleared by the load, so adding N leaves exactly N
                    osr_shift_en = 1'b1;
                    cnt_add      = 1'b1;
                    done         = 1'b1;
                    state_nx     = IDLE;
                end
                OUT_WAIT: begin
                    if (!autopull_en) begin
                        osr_shift_en = 1'b1;
                        cnt_add      = 1'b1;
                        done         = 1'b1;
                        state_nx     = IDLE;
                    end else if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        osr_load  = 1'b1;
                        cnt_clear = 1'b1;
                        state_nx  = OUT_REFILL;
                    end
                end
                PULL_WAIT: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        osr_load  = 1'b1;
                        cnt_clear = 1'b1;
                        done      = 1'b1;
                        state_nx  = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        stall         = !rst && (mov_req || pull_req || out_req) && !done;
        osr_shift_cnt = osr_shift_en ? bits_val : 6'd0;
    end

    // load-value mux; only meaningful while osr_load is high
    always_comb begin
        unique case (load_src)
            SRC_X:   osr_data_in = x_reg;
            SRC_MOV: osr_data_in = mov_data;
            default: osr_data_in = fifo_data;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

endmodule

// File: tb/tb_osr_ctrl.sv
// Self-checking bench for osr_ctrl: directed scenarios followed by random
// request/FIFO/config traffic, all checked cycle by cycle against a
// behavioural model that owns the TX FIFO as a queue.
module tb_osr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_req = 1'b0;
    logic [4:0]  out_bits = '0;
    logic        pull_req = 1'b0;
    logic        pull_block = 1'b0;
    logic        pull_ifempty = 1'b0;
    logic        mov_req = 1'b0;
    logic [31:0] mov_data = '0;
    logic [31:0] x_reg = '0;
    logic        autopull_en = 1'b0;
    logic [4:0]  pull_thresh = '0;
    logic [31:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_pop;
    logic        osr_load;
    logic [31:0] osr_data_in;
    logic        osr_shift_en;
    logic [5:0]  osr_shift_cnt;
    logic        done;
    logic        stall;
    logic [5:0]  osr_count;

    int total = 0;
    int bad = 0;

    logic [31:0] fifo_q[$];

    // model state: bits held in the OSR and what kind of wait is outstanding
    int m_count = 32;
    bit m_out_ready = 0, m_out_wait = 0, m_pull_wait = 0;
    int n_count;
    bit n_out_ready, n_out_wait, n_pull_wait;

    // model expectations for the current cycle
    bit e_pop, e_load, e_shift, e_done, e_stall;
    logic [31:0] e_data;
    int e_scnt;
    int e_kind;

    // last observed outputs, for directed checks
    bit obs_pop, obs_load, obs_shift, obs_done, obs_stall;
    logic [31:0] obs_data;
    int obs_scnt;

    osr_ctrl #(.W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .out_req       (out_req),
        .out_bits      (out_bits),
        .pull_req      (pull_req),
        .pull_block    (pull_block),
        .pull_ifempty  (pull_ifempty),
        .mov_req       (mov_req),
        .mov_data      (mov_data),
        .x_reg         (x_reg),
        .autopull_en   (autopull_en),
        .pull_thresh   (pull_thresh),
        .fifo_data     (fifo_data),
        .fifo_empty    (fifo_empty),
        .fifo_pop      (fifo_pop),
        .osr_load      (osr_load),
        .osr_data_in   (osr_data_in),
        .osr_shift_en  (osr_shift_en),
        .osr_shift_cnt (osr_shift_cnt),
        .done          (done),
        .stall         (stall),
        .osr_count     (osr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    endtask

    task automatic push(input logic [31:0] v);
        fifo_q.push_back(v);
        sync_fifo();
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 32) ? 32 : a + b;
    endfunction

    // behavioural reference: what the sequencer must do this cycle
    task automatic model_eval();
        int  t, n;
        bit  empty, due;
        logic [31:0] head;
        t = (pull_thresh == 0) ? 32 : int'(pull_thresh);
        n = (out_bits == 0) ? 32 : int'(out_bits);
        empty = (fifo_q.size() == 0);
        head  = empty ? 32'h0 : fifo_q[0];
        due   = autopull_en && (m_count >= t);
        e_pop = 0; e_load = 0; e_shift = 0; e_done = 0; e_data = '0; e_scnt = 0; e_kind = 0;
        n_count = m_count; n_out_ready = m_out_ready; n_out_wait = m_out_wait; n_pull_wait = m_pull_wait;
        if (rst) begin
            n_count = 32; n_out_ready = 0; n_out_wait = 0; n_pull_wait = 0;
        end else if (m_out_ready) begin
            e_shift = 1; e_scnt = n; e_done = 1; e_kind = 3;
            n_count = n; n_out_ready = 0;
        end else if (m_out_wait) begin
            if (!autopull_en) begin
                e_shift = 1; e_scnt = n; e_done = 1; e_kind = 3;
                n_count = sat_add(m_count, n); n_out_wait = 0;
            end else if (!empty) begin
                e_pop = 1; e_load = 1; e_data = head;
                n_count = 0; n_out_wait = 0; n_out_ready = 1;
            end
        end else if (m_pull_wait) begin
            if (!empty) begin
                e_pop = 1; e_load = 1; e_data = head; e_done = 1; e_kind = 2;
                n_count = 0; n_pull_wait = 0;
            end
        end else if (mov_req) begin
            e_load = 1; e_data = mov_data; e_done = 1; e_kind = 1; n_count = 0;
        end else if (pull_req) begin
            if (pull_ifempty && m_count < t) begin
                e_done = 1; e_kind = 2;
            end else if (!empty) begin
                e_pop = 1; e_load = 1; e_data = head; e_done = 1; e_kind = 2; n_count = 0;
            end else if (pull_block) begin
                n_pull_wait = 1;
            end else begin
                e_load = 1; e_data = x_reg; e_done = 1; e_kind = 2; n_count = 0;
            end
        end else if (out_req) begin
            if (due) begin
                if (!empty) begin
                    e_pop = 1; e_load = 1; e_data = head; n_count = 0; n_out_ready = 1;
                end else begin
                    n_out_wait = 1;
                end
            end else begin
                e_shift = 1; e_scnt = n; e_done = 1; e_kind = 3;
                n_count = sat_add(m_count, n);
            end
        end
`ifdef OSR_CTRL_BG_REFILL_EN
        else if (due && !empty) begin
            e_pop = 1; e_load = 1; e_data = head; n_count = 0;
        end
`endif
        e_stall = !rst && (mov_req || pull_req || out_req) && !e_done;
    endtask

    // one clock cycle: check outputs mid-cycle, advance model, retire completed requests
    task automatic step();
        @(negedge clk);
        model_eval();
        obs_pop = fifo_pop; obs_load = osr_load; obs_shift = osr_shift_en;
        obs_done = done; obs_stall = stall; obs_data = osr_data_in; obs_scnt = int'(osr_shift_cnt);
        check("pop", {31'b0, fifo_pop}, {31'b0, e_pop});
        check("load", {31'b0, osr_load}, {31'b0, e_load});
        if (e_load) check("load_data", osr_data_in, e_data);
        check("shift_en", {31'b0, osr_shift_en}, {31'b0, e_shift});
        if (e_shift) check("shift_cnt", {26'b0, osr_shift_cnt}, e_scnt);
        check("done", {31'b0, done}, {31'b0, e_done});
        check("stall", {31'b0, stall}, {31'b0, e_stall});
        if (!rst) check("count", {26'b0, osr_count}, m_count);
        m_count = n_count; m_out_ready = n_out_ready; m_out_wait = n_out_wait; m_pull_wait = n_pull_wait;
        @(posedge clk);
        #1;
        if (e_pop) void'(fifo_q.pop_front());
        if (e_kind == 1) mov_req = 1'b0;
        if (e_kind == 2) pull_req = 1'b0;
        if (e_kind == 3) out_req = 1'b0;
        sync_fifo();
    endtask

    initial begin
        int r;
        sync_fifo();
        // reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_count", {26'b0, osr_count}, 32'd32);
        check("rst_stall", {31'b0, obs_stall}, 32'd0);

        // OUT with autopull on an empty OSR and empty FIFO waits for a push
        autopull_en = 1'b1; pull_thresh = 5'd0;
        out_req = 1'b1; out_bits = 5'd8;
        step();
        check("ap_wait_stall", {31'b0, obs_stall}, 32'd1);
        step();
        check("ap_wait_stall2", {31'b0, obs_stall}, 32'd1);
        push(32'h12345678);
        step();
        check("ap_pop", {31'b0, obs_pop}, 32'd1);
        check("ap_load_data", obs_data, 32'h12345678);
        step();
        check("ap_shift_cnt", obs_scnt, 32'd8);
        check("ap_done", {31'b0, obs_done}, 32'd1);
        check("ap_count", {26'b0, osr_count}, 32'd8);
        autopull_en = 1'b0;

        // MOV loads in one cycle
        mov_req = 1'b1; mov_data = 32'hDEADBEEF;
        step();
        check("mov_load", {31'b0, obs_load}, 32'd1);
        check("mov_data", obs_data, 32'hDEADBEEF);
        check("mov_done", {31'b0, obs_done}, 32'd1);
        check("mov_count", {26'b0, osr_count}, 32'd0);

        // OUT 32 empties the OSR; a further OUT saturates
        out_req = 1'b1; out_bits = 5'd0;
        step();
        check("out32_cnt", obs_scnt, 32'd32);
        check("out32_count", {26'b0, osr_count}, 32'd32);
        out_req = 1'b1; out_bits = 5'd4;
        step();
        check("sat_shift", {31'b0, obs_shift}, 32'd1);
        check("sat_count", {26'b0, osr_count}, 32'd32);

        // blocking PULL on empty FIFO
        pull_req = 1'b1; pull_block = 1'b1; pull_ifempty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("pullblk_stall", {31'b0, obs_stall}, 32'd1);
        end
        push(32'hA1B2C3D4);
        step();
        check("pullblk_pop", {31'b0, obs_pop}, 32'd1);
        check("pullblk_data", obs_data, 32'hA1B2C3D4);

        // non-blocking PULL on empty FIFO takes X
        pull_req = 1'b1; pull_block = 1'b0; x_reg = 32'h5A5A0F0F;
        step();
        check("pullx_data", obs_data, 32'h5A5A0F0F);
        check("pullx_pop", {31'b0, obs_pop}, 32'd0);

        // PULL ifempty below threshold is a no-op
        out_req = 1'b1; out_bits = 5'd8;
        step();
        pull_thresh = 5'd16; push(32'h00000001);
        pull_req = 1'b1; pull_ifempty = 1'b1;
        step();
        check("ifempty_done", {31'b0, obs_done}, 32'd1);
        check("ifempty_load", {31'b0, obs_load}, 32'd0);
        check("ifempty_pop", {31'b0, obs_pop}, 32'd0);
        pull_ifempty = 1'b0;

        // MOV beats OUT; OUT completes the following cycle
        mov_req = 1'b1; mov_data = 32'h0BADF00D; out_req = 1'b1; out_bits = 5'd8;
        step();
        check("prio_mov_load", {31'b0, obs_load}, 32'd1);
        check("prio_out_shift", {31'b0, obs_shift}, 32'd0);
        step();
        check("prio_out_done", {31'b0, obs_done}, 32'd1);

        // drain the FIFO, then reset while an OUT waits for a refill
        pull_req = 1'b1; pull_block = 1'b1;
        step();
        out_req = 1'b1; out_bits = 5'd8;
        step();
        autopull_en = 1'b1; pull_thresh = 5'd4; out_req = 1'b1; out_bits = 5'd4;
        step();
        check("rstw_stall", {31'b0, obs_stall}, 32'd1);
        rst = 1'b1; out_req = 1'b0;
        step();
        check("rstw_pop", {31'b0, obs_pop}, 32'd0);
        rst = 1'b0;
        step();
        check("rstw_count", {26'b0, osr_count}, 32'd32);

        // idle push with autopull on an empty OSR
        pull_thresh = 5'd0;
        push(32'hCAFEF00D);
        step();
`ifdef OSR_CTRL_BG_REFILL_EN
        check("bg_pop", {31'b0, obs_pop}, 32'd1);
        check("bg_count", {26'b0, osr_count}, 32'd0);
`else
        check("bg_pop", {31'b0, obs_pop}, 32'd0);
        check("bg_count", {26'b0, osr_count}, 32'd32);
`endif

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1; mov_req = 1'b0; pull_req = 1'b0; out_req = 1'b0;
            end else begin
                rst = 1'b0;
            end
            if (!rst && !mov_req && !pull_req && !out_req && $urandom_range(0, 1) == 0) begin
                r = int'($urandom_range(0, 7));
                mov_req  = (r == 0) || (r == 7);
                pull_req = (r >= 1) && (r <= 3);
                out_req  = (r >= 4);
                mov_data = $urandom;
                x_reg    = $urandom;
                pull_block   = 1'($urandom_range(0, 1));
                pull_ifempty = 1'($urandom_range(0, 1));
                out_bits     = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 39) == 0) autopull_en = ~autopull_en;
            if ($urandom_range(0, 39) == 0) pull_thresh = 5'($urandom_range(0, 31));
            if (fifo_q.size() < 4 && $urandom_range(0, 3) == 0) push($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
